// File: rtl/mem_stage_pkg.sv
// Shared Y86 constants and helpers for the memory stage.
package mem_stage_pkg;

  localparam int WORD   = 32;
  localparam int NIBBLE = 4;

  localparam logic [NIBBLE-1:0] I_HALT   = 4'h0;
  localparam logic [NIBBLE-1:0] I_NOP    = 4'h1;
  localparam logic [NIBBLE-1:0] I_CMOVXX = 4'h2;
  localparam logic [NIBBLE-1:0] I_IRMOVL = 4'h3;
  localparam logic [NIBBLE-1:0] I_RMMOVL = 4'h4;
  localparam logic [NIBBLE-1:0] I_MRMOVL = 4'h5;
  localparam logic [NIBBLE-1:0] I_OPL    = 4'h6;
  localparam logic [NIBBLE-1:0] I_JXX    = 4'h7;
  localparam logic [NIBBLE-1:0] I_CALL   = 4'h8;
  localparam logic [NIBBLE-1:0] I_RET    = 4'h9;
  localparam logic [NIBBLE-1:0] I_PUSHL  = 4'hA;
  localparam logic [NIBBLE-1:0] I_POPL   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [NIBBLE-1:0] RNONE = 4'hF;

  typedef enum logic {ST_IDLE, ST_WAIT} ctrl_state_e;

  function automatic logic is_mem_read(input logic [NIBBLE-1:0] icode);
    return (icode == I_MRMOVL) || (icode == I_RET) || (icode == I_POPL);
  endfunction

  function automatic logic is_mem_write(input logic [NIBBLE-1:0] icode);
    return (icode == I_RMMOVL) || (icode == I_CALL) || (icode == I_PUSHL);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl.sv
// Data-memory handshake controller: IDLE/WAIT FSM, wait-state timeout
// counter and pipeline stall generation.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic want_i,
  input  logic ack_i,
  input  logic load_i,
  output logic req_o,
  output logic stall_o,
  output logic fault_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  ctrl_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fault_q;

  // A timed-out access leaves the instruction in M for one more cycle with
  // the request suppressed, so it retires with ADR.
  assign req_o   = (state_q == ST_WAIT) || (want_i && !fault_q);
  assign stall_o = req_o && !ack_i;
  assign fault_o = fault_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      if (load_i) fault_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_o && !ack_i) begin
            if (TIMEOUT <= 1) begin
              fault_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (ack_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Y86 memory stage: M pipeline register, address/fault datapath and dmem bus.
// Optional MEM_ALIGN_CHECK_EN: misaligned word addresses fault with ADR.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int              TIMEOUT   = 16,
  parameter logic [WORD-1:0] MEM_LIMIT = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD-1:0]   e_valE_i,
  input  logic [WORD-1:0]   E_valA_i,
  input  logic [NIBBLE-1:0] E_icode_i,
  input  logic [NIBBLE-1:0] e_dstE_i,
  input  logic [NIBBLE-1:0] E_dstM_i,
  input  logic              e_Cnd_i,
  input  logic [2:0]        E_stat_i,
  input  logic              M_bubble_i,
  input  logic              W_exc_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [WORD-1:0]   dmem_addr_o,
  output logic [WORD-1:0]   dmem_wdata_o,
  input  logic [WORD-1:0]   dmem_rdata_i,
  input  logic              dmem_ack_i,
  output logic [NIBBLE-1:0] m_icode_o,
  output logic [WORD-1:0]   m_valE_o,
  output logic [WORD-1:0]   m_valM_o,
  output logic [NIBBLE-1:0] m_dstE_o,
  output logic [NIBBLE-1:0] m_dstM_o,
  output logic [2:0]        m_stat_o,
  output logic              m_stall_o
);

  logic [NIBBLE-1:0] icode_q, icode_d, dstE_q, dstE_d, dstM_q, dstM_d;
  logic [WORD-1:0]   valE_q, valE_d, valA_q, valA_d;
  logic [2:0]        stat_q, stat_d;
  logic              rd_op, wr_op, mem_op, addr_bad, want, req, fault, load;
  logic [WORD-1:0]   addr;

  assign load = !m_stall_o;

  always_comb begin
    icode_d = icode_q;
    valE_d  = valE_q;
    valA_d  = valA_q;
    dstE_d  = dstE_q;
    dstM_d  = dstM_q;
    stat_d  = stat_q;
    if (load) begin
      if (M_bubble_i) begin
        icode_d = I_NOP;
        valE_d  = '0;
        valA_d  = '0;
        dstE_d  = RNONE;
        dstM_d  = RNONE;
        stat_d  = S_AOK;
      end else begin
        icode_d = E_icode_i;
        valE_d  = e_valE_i;
        valA_d  = E_valA_i;
        dstE_d  = (E_icode_i == I_CMOVXX && !e_Cnd_i) ? RNONE : e_dstE_i;
        dstM_d  = E_dstM_i;
        stat_d  = E_stat_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icode_q <= I_NOP;
      valE_q  <= '0;
      valA_q  <= '0;
      dstE_q  <= RNONE;
      dstM_q  <= RNONE;
      stat_q  <= S_AOK;
    end else begin
      icode_q <= icode_d;
      valE_q  <= valE_d;
      valA_q  <= valA_d;
      dstE_q  <= dstE_d;
      dstM_q  <= dstM_d;
      stat_q  <= stat_d;
    end
  end

  assign rd_op  = is_mem_read(icode_q);
  assign wr_op  = is_mem_write(icode_q);
  assign mem_op = rd_op || wr_op;
  assign addr   = (icode_q == I_RET || icode_q == I_POPL) ? valA_q : valE_q;

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_bad = (addr >= MEM_LIMIT) || (addr[1:0] != 2'b00);
`else
  assign addr_bad = (addr >= MEM_LIMIT);
`endif

  // Writes are held back behind an excepting W stage; reads may proceed.
  assign want = mem_op && (stat_q == S_AOK) && !addr_bad && (rd_op || !W_exc_i);

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .want_i  (want),
    .ack_i   (dmem_ack_i),
    .load_i  (load),
    .req_o   (req),
    .stall_o (m_stall_o),
    .fault_o (fault)
  );

  assign dmem_req_o   = req;
  assign dmem_we_o    = req && wr_op;
  assign dmem_addr_o  = req ? addr : '0;
  assign dmem_wdata_o = (req && wr_op) ? valA_q : '0;

  assign m_valM_o  = (req && rd_op && dmem_ack_i) ? dmem_rdata_i : '0;
  assign m_valE_o  = valE_q;
  assign m_icode_o = icode_q;
  assign m_dstE_o  = dstE_q;
  assign m_dstM_o  = dstM_q;

  always_comb begin
    m_stat_o = S_AOK;
    if (stat_q != S_AOK)          m_stat_o = stat_q;
    else if (mem_op && addr_bad)  m_stat_o = S_ADR;
    else if (fault)               m_stat_o = S_ADR;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: each instruction's expected M-stage result
// is queued at issue and compared when the stage releases it.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 16;

  logic        clk, rst;
  logic [31:0] e_valE_i, E_valA_i, dmem_rdata_i;
  logic [3:0]  E_icode_i, e_dstE_i, E_dstM_i;
  logic        e_Cnd_i, M_bubble_i, W_exc_i, dmem_ack_i;
  logic [2:0]  E_stat_i;
  logic        dmem_req_o, dmem_we_o, m_stall_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, m_valE_o, m_valM_o;
  logic [3:0]  m_icode_o, m_dstE_o, m_dstM_o;
  logic [2:0]  m_stat_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        req_first, req_last, we;
    logic [31:0] addr, wdata, valE, valM;
    logic [3:0]  dstE, dstM, icode;
    logic [2:0]  stat;
    int          stalls;
  } exp_t;

  exp_t sb[$];

  mem_stage #(.TIMEOUT(TO), .MEM_LIMIT(32'h0000_1000)) dut (
    .clk(clk), .rst(rst),
    .e_valE_i(e_valE_i), .E_valA_i(E_valA_i), .E_icode_i(E_icode_i),
    .e_dstE_i(e_dstE_i), .E_dstM_i(E_dstM_i), .e_Cnd_i(e_Cnd_i),
    .E_stat_i(E_stat_i), .M_bubble_i(M_bubble_i), .W_exc_i(W_exc_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .m_icode_o(m_icode_o), .m_valE_o(m_valE_o), .m_valM_o(m_valM_o),
    .m_dstE_o(m_dstE_o), .m_dstM_o(m_dstM_o), .m_stat_o(m_stat_o), .m_stall_o(m_stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] ic, input logic [31:0] ve, input logic [31:0] va,
                                 input logic [3:0] de, input logic [3:0] dm, input logic cnd,
                                 input logic [2:0] st, input logic wexc, input int delay,
                                 input logic [31:0] rd);
    exp_t e;
    logic rd_op, wr_op, badaddr, go;
    logic [31:0] a;
    rd_op = (ic == I_MRMOVL) || (ic == I_RET) || (ic == I_POPL);
    wr_op = (ic == I_RMMOVL) || (ic == I_CALL) || (ic == I_PUSHL);
    a = (ic == I_RET || ic == I_POPL) ? va : ve;
    badaddr = (a >= 32'h0000_1000);
`ifdef MEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) badaddr = 1'b1;
`endif
    go = (rd_op || wr_op) && (st == S_AOK) && !badaddr && (rd_op || !wexc);
    e.req_first = go;
    e.we        = wr_op;
    e.addr      = a;
    e.wdata     = va;
    e.valE      = ve;
    e.dstE      = (ic == I_CMOVXX && !cnd) ? RNONE : de;
    e.dstM      = dm;
    e.icode     = ic;
    if (!go) begin
      e.stalls = 0; e.req_last = 1'b0; e.valM = 32'h0;
      e.stat = (st != S_AOK) ? st : ((rd_op || wr_op) && badaddr) ? S_ADR : S_AOK;
    end else if (delay < 0 || delay >= TO) begin
      e.stalls = TO; e.req_last = 1'b0; e.valM = 32'h0; e.stat = S_ADR;
    end else begin
      e.stalls = delay; e.req_last = 1'b1; e.valM = rd_op ? rd : 32'h0; e.stat = S_AOK;
    end
    return e;
  endfunction

  // Call with inputs settled between edges; returns one cycle after the
  // instruction leaves M, with a bubble then occupying M.
  task automatic run_txn(input string tag, input logic [3:0] ic, input logic [31:0] ve,
                         input logic [31:0] va, input logic [3:0] de, input logic [3:0] dm,
                         input logic cnd, input logic [2:0] st, input logic wexc,
                         input int delay, input logic [31:0] rd);
    exp_t e;
    logic f_req, f_we, l_req, l_we, done;
    logic [31:0] f_addr, f_wdata, l_valE, l_valM;
    logic [3:0]  l_dstE, l_dstM, l_icode;
    logic [2:0]  l_stat;
    int stalls;
    E_icode_i = ic; e_valE_i = ve; E_valA_i = va; e_dstE_i = de; E_dstM_i = dm;
    e_Cnd_i = cnd; E_stat_i = st; W_exc_i = wexc; M_bubble_i = 1'b0;
    sb.push_back(model(ic, ve, va, de, dm, cnd, st, wexc, delay, rd));
    @(posedge clk); #1;
    M_bubble_i = 1'b1;
    E_icode_i = I_NOP;
    done = 1'b0; stalls = 0;
    f_req = 0; f_we = 0; f_addr = 0; f_wdata = 0; l_req = 0; l_we = 0;
    l_valE = 0; l_valM = 0; l_dstE = 0; l_dstM = 0; l_icode = 0; l_stat = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      dmem_ack_i = (delay >= 0) && (k == delay);
      dmem_rdata_i = rd;
      #1;
      if (k == 0) begin
        f_req = dmem_req_o; f_we = dmem_we_o; f_addr = dmem_addr_o; f_wdata = dmem_wdata_o;
      end
      if (!m_stall_o) begin
        done = 1'b1; stalls = k;
        l_req = dmem_req_o; l_we = dmem_we_o; l_valE = m_valE_o; l_valM = m_valM_o;
        l_dstE = m_dstE_o; l_dstM = m_dstM_o; l_icode = m_icode_o; l_stat = m_stat_o;
      end else begin
        @(posedge clk); #1;
      end
    end
    check_val({tag, ".released"}, {31'h0, done}, 32'h1);
    e = sb.pop_front();
    check_val({tag, ".req_first"}, {31'h0, f_req}, {31'h0, e.req_first});
    if (e.req_first) begin
      check_val({tag, ".we"}, {31'h0, f_we}, {31'h0, e.we});
      check_val({tag, ".addr"}, f_addr, e.addr);
      if (e.we) check_val({tag, ".wdata"}, f_wdata, e.wdata);
    end
    check_val({tag, ".req_last"}, {31'h0, l_req}, {31'h0, e.req_last});
    check_val({tag, ".stalls"}, stalls, e.stalls);
    check_val({tag, ".valE"}, l_valE, e.valE);
    check_val({tag, ".valM"}, l_valM, e.valM);
    check_val({tag, ".dstE"}, {28'h0, l_dstE}, {28'h0, e.dstE});
    check_val({tag, ".dstM"}, {28'h0, l_dstM}, {28'h0, e.dstM});
    check_val({tag, ".icode"}, {28'h0, l_icode}, {28'h0, e.icode});
    check_val({tag, ".stat"}, {29'h0, l_stat}, {29'h0, e.stat});
    $display("txn %s icode=%h addr=%h stalls=%0d stat=%0d valM=%h", tag, l_icode, f_addr,
             stalls, l_stat, l_valM);
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    W_exc_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    e_valE_i = 0; E_valA_i = 0; E_icode_i = I_NOP; e_dstE_i = RNONE; E_dstM_i = RNONE;
    e_Cnd_i = 1'b0; E_stat_i = S_AOK; M_bubble_i = 1'b1; W_exc_i = 1'b0;
    dmem_ack_i = 1'b0; dmem_rdata_i = 0;
    #22;
    check_val("rst.req", {31'h0, dmem_req_o}, 32'h0);
    check_val("rst.we", {31'h0, dmem_we_o}, 32'h0);
    check_val("rst.addr", dmem_addr_o, 32'h0);
    check_val("rst.wdata", dmem_wdata_o, 32'h0);
    check_val("rst.valE", m_valE_o, 32'h0);
    check_val("rst.valM", m_valM_o, 32'h0);
    check_val("rst.dstE", {28'h0, m_dstE_o}, 32'hF);
    check_val("rst.dstM", {28'h0, m_dstM_o}, 32'hF);
    check_val("rst.icode", {28'h0, m_icode_o}, 32'h1);
    check_val("rst.stat", {29'h0, m_stat_o}, 32'h1);
    check_val("rst.stall", {31'h0, m_stall_o}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_txn("rmmovl",  I_RMMOVL, 32'h100, 32'hDEADBEEF, RNONE, RNONE, 1, S_AOK, 0, 0, 32'h0);
    run_txn("mrmovl3", I_MRMOVL, 32'h200, 32'h0, RNONE, 4'h2, 1, S_AOK, 0, 3, 32'h12345678);
    run_txn("popl",    I_POPL, 32'h84, 32'h80, 4'h4, 4'h3, 1, S_AOK, 0, 1, 32'h0000CAFE);
    run_txn("pushl_lim", I_PUSHL, 32'h2000, 32'h55, 4'h4, RNONE, 1, S_AOK, 0, 0, 32'h0);
    run_txn("pushl_wexc", I_PUSHL, 32'h40, 32'h55, 4'h4, RNONE, 1, S_AOK, 1, 0, 32'h0);
    run_txn("mrmovl_wexc", I_MRMOVL, 32'h44, 32'h0, RNONE, 4'h1, 1, S_AOK, 1, 0, 32'hA5A5A5A5);
    run_txn("call",    I_CALL, 32'h7C, 32'h1234, 4'h4, RNONE, 1, S_AOK, 0, 2, 32'h0);
    run_txn("ret",     I_RET, 32'h80, 32'h7C, 4'h4, RNONE, 1, S_AOK, 0, 0, 32'h1234);
    run_txn("timeout", I_MRMOVL, 32'h300, 32'h0, RNONE, 4'h5, 1, S_AOK, 0, -1, 32'h0);
    run_txn("after_to", I_OPL, 32'h9, 32'h0, 4'h6, RNONE, 1, S_AOK, 0, 0, 32'h0);
    run_txn("misalign", I_MRMOVL, 32'h102, 32'h0, RNONE, 4'h7, 1, S_AOK, 0, 0, 32'h00000055);
    run_txn("cmov_nc", I_CMOVXX, 32'h11, 32'h11, 4'h3, RNONE, 0, S_AOK, 0, 0, 32'h0);
    run_txn("cmov_c",  I_CMOVXX, 32'h22, 32'h22, 4'h3, RNONE, 1, S_AOK, 0, 0, 32'h0);
    run_txn("halt",    I_HALT, 32'h0, 32'h0, RNONE, RNONE, 1, S_HLT, 0, 0, 32'h0);
    run_txn("ins_ld",  I_MRMOVL, 32'h10, 32'h0, RNONE, 4'h2, 1, S_INS, 0, 0, 32'h0);

    // Ack with no request in flight must not produce data or a stall.
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
    #1;
    check_val("stray_ack.valM", m_valM_o, 32'h0);
    check_val("stray_ack.stall", {31'h0, m_stall_o}, 32'h0);
    $display("txn stray_ack valM=%h stall=%0d", m_valM_o, m_stall_o);
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;

    // Reset asserted while the controller is waiting on an ack.
    E_icode_i = I_MRMOVL; e_valE_i = 32'h300; E_valA_i = 0; e_dstE_i = RNONE; E_dstM_i = 4'h1;
    E_stat_i = S_AOK; M_bubble_i = 1'b0;
    @(posedge clk); #1;
    M_bubble_i = 1'b1; E_icode_i = I_NOP;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("rstwait.req_before", {31'h0, dmem_req_o}, 32'h1);
    #1 rst = 1'b0;
    #1;
    check_val("rstwait.req", {31'h0, dmem_req_o}, 32'h0);
    check_val("rstwait.stall", {31'h0, m_stall_o}, 32'h0);
    check_val("rstwait.icode", {28'h0, m_icode_o}, 32'h1);
    $display("txn rst_in_wait req=%0d stall=%0d", dmem_req_o, m_stall_o);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_val("rstwait.after", {31'h0, dmem_req_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the Y86 five-stage pipeline: owns the M pipeline register fed by execute (e_valE, e_dstE, e_Cnd plus forwarded E fields) and performs the data-memory access for RMMOVL/MRMOVL/CALL/RET/PUSHL/POPL over a req/ack bus with a wait-state timeout. It drives m_* results to the W register and forwarding logic and stalls the pipe while an access is outstanding.

## Interface
- Parameters:
- TIMEOUT, 16, max wait cycles for dmem_ack before ADR fault (≥1)
- MEM_LIMIT, 32'h0000_1000, first invalid byte address
- Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- e_valE_i / E_valA_i  in  32  ALU result / valA (valP for CALL)
- E_icode_i  in  4  instruction code; e_dstE_i, E_dstM_i  in  4  destination regs
- e_Cnd_i  in  1  condition; E_stat_i  in  3  status
- M_bubble_i  in  1  hazard unit: load NOP instead of E fields
- W_exc_i  in  1  W stage holds non-AOK status; suppresses new memory writes
- dmem_req_o / dmem_we_o  out  1  request / write enable
- dmem_addr_o / dmem_wdata_o  out  32  address / write data
- dmem_rdata_i  in  32; dmem_ack_i  in  1  access complete
- m_icode_o  out  4; m_valE_o, m_valM_o  out  32; m_dstE_o, m_dstM_o  out  4; m_stat_o  out  3
- m_stall_o  out  1  hold F/D/E and M register

## Operation
- Codes: HALT 0, NOP 1, CMOVXX 2, IRMOVL 3, RMMOVL 4, MRMOVL 5, OPL 6, JXX 7, CALL 8, RET 9, PUSHL A, POPL B; stat AOK 1, HLT 2, ADR 3, INS 4; RNONE F.
- M register load: if m_stall_o hold; else if M_bubble_i load NOP/AOK/RNONE; else load E fields. CMOVXX with e_Cnd_i=0 loads dstE=RNONE.
- Address: valA for RET/POPL, else valE. Write ops RMMOVL/CALL/PUSHL (wdata=valA); read ops MRMOVL/RET/POPL.
- Address fault: addr ≥ MEM_LIMIT → no request, m_stat_o=ADR.
- Request only if mem op, M_stat AOK, address valid; writes additionally require W_exc_i=0 (reads proceed).
- FSM IDLE/WAIT: IDLE with request → req high; ack same cycle → done, stay IDLE; else → WAIT, counter=1. WAIT: hold req/addr/data/we stable; ack → IDLE; counter reaches TIMEOUT → IDLE, latch fault flag, m_stat_o=ADR for that instruction.
- m_stall_o = request active & !dmem_ack_i & !timeout.
- m_valM_o = dmem_rdata_i in ack cycle for reads, else 0. m_valE_o/m_dstE_o/m_dstM_o/m_icode_o pass from M register.
- Fault flag clears when M register next loads.

## Timing
- Reset (async): M register = NOP/AOK/RNONE/0, FSM IDLE, counter 0, fault 0; outputs req 0, we 0, addr 0, wdata 0, m_valE/m_valM 0, dsts F, icode 1, stat AOK, stall 0.
- Reset mid-WAIT: req drops immediately, no ack expected.
- Zero-wait access: 1 cycle in M, no stall. N-wait: stall N cycles, result on cycle with ack.
- Timeout: stall exactly TIMEOUT cycles, then ADR, req deasserted next cycle.
- Ack outside request ignored. M_bubble_i while stalled ignored.

## Configuration
- MEM_ALIGN_CHECK_EN defined: addr[1:0]≠0 on a mem op → ADR, no request.
- Undefined: misaligned addresses issued unchanged; only MEM_LIMIT check.

## Structure
- Shared package/defines: icode, ifun, stat, RNONE constants, WORD/NIBBLE widths (existing defines.v).
- One sub-module: mem_stage_ctrl (IDLE/WAIT FSM, timeout counter, stall); datapath and M register in top.

## Test plan
- RMMOVL valE=0x100, valA=0xDEADBEEF, ack same cycle → req/we=1, addr 0x100, wdata 0xDEADBEEF, stall 0, stat AOK.
- MRMOVL valE=0x200, ack after 3 cycles, rdata 0x12345678 → stall 3 cycles, m_valM 0x12345678 in ack cycle.
- POPL valA=0x80, valE=0x84 → addr 0x80, m_valE 0x84, dstM from E_dstM.
- PUSHL valE=0x2000 (≥MEM_LIMIT) → no req, m_stat ADR; with W_exc_i=1 on valid PUSHL → no req.
- MRMOVL, ack never, TIMEOUT=16 → stall 16 cycles, then stat ADR, req low.
- With MEM_ALIGN_CHECK_EN, MRMOVL addr 0x102 → ADR, no req; without it → req addr 0x102. Reset asserted in WAIT → req 0 same instant.
